// File: rtl/fsqrt_iter.sv
// Iterative IEEE-754 square root for any EXP_W/MAN_W format, UNROLL root bits per cycle.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender holds its data until then.
module fsqrt_iter #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int UNROLL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [2:0]               in_rm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_z,
  output logic [4:0]               out_flags,
  output logic                     busy
);
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int N  = MAN_W + 2;
  localparam int K  = (N + UNROLL - 1) / UNROLL;
  localparam int M  = K * UNROLL;
  localparam int RW = 2 * M;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(K + 1);
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0]  INF  = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, CLASSIFY, ITER, ROUND, DONE} state_t;
  state_t state;

  logic [W-1:0]   a_q;
  logic [2:0]     rm_q;
  logic           special_q, spec_nv_q;
  logic [W-1:0]   spec_z_q;
  logic [EW-1:0]  e_q;
  logic [RW-1:0]  rad_q;
  logic [M+1:0]   rem_q;
  logic [M-1:0]   root_q;
  logic [CW-1:0]  cnt_q;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Classification and normalisation of the latched operand
  logic                 a_sign;
  logic [EXP_W-1:0]     a_exp;
  logic [MAN_W-1:0]     a_man;
  logic [MAN_W:0]       sig_raw, sig_norm;
  logic [MAN_W+1:0]     sig_even;
  logic [EW-1:0]        lz, e_unb, e_even;
  logic                 c_special, c_nv;
  logic [W-1:0]         c_z;

  assign {a_sign, a_exp, a_man} = a_q;

  always_comb begin
    sig_raw = {(a_exp != '0), a_man};
    lz = '0;
    for (int i = 0; i <= MAN_W; i++)
      if (sig_raw[i]) lz = EW'(MAN_W - i);
    sig_norm = sig_raw << lz;
    if (a_exp == '0) e_unb = EW'(1) - BIAS - lz;
    else             e_unb = {2'b00, a_exp} - BIAS;
    // odd exponent: fold one factor of two into the radicand
    if (e_unb[0]) begin
      sig_even = {sig_norm, 1'b0};
      e_even   = e_unb - EW'(1);
    end else begin
      sig_even = {1'b0, sig_norm};
      e_even   = e_unb;
    end
    c_special = 1'b1;
    c_nv      = 1'b0;
    c_z       = QNAN;
    if (rm_q > 3'd4) c_nv = 1'b1;
    else if (a_exp == {EXP_W{1'b1}}) begin
      if (a_man != '0)  c_nv = ~a_man[MAN_W-1];
      else if (a_sign)  c_nv = 1'b1;
      else              c_z  = INF;
    end
    else if (a_exp == '0 && a_man == '0) c_z = a_q;
    else if (a_sign) c_nv = 1'b1;
    else c_special = 1'b0;
  end

  // Restoring recurrence, UNROLL steps per cycle
  logic [M+3:0]  acc, trial;
  logic [M+1:0]  it_rem;
  logic [M-1:0]  it_root;
  logic [RW-1:0] it_rad;

  always_comb begin
    it_rem  = rem_q;
    it_root = root_q;
    it_rad  = rad_q;
    acc     = '0;
    trial   = '0;
    for (int u = 0; u < UNROLL; u++) begin
      acc   = {it_rem, it_rad[RW-1 -: 2]};
      trial = {2'b00, it_root, 2'b01};
      if (acc >= trial) begin
        acc     = acc - trial;
        it_root = {it_root[M-2:0], 1'b1};
      end else begin
        it_root = {it_root[M-2:0], 1'b0};
      end
      it_rem = acc[M+1:0];
      it_rad = it_rad << 2;
    end
  end

  // Rounding: root_q[0] is the guard bit, the remainder supplies sticky
  logic             g, s, inc;
  logic [MAN_W:0]   mant_sum;
  logic [EW-1:0]    exp_r;
  logic [EXP_W-1:0] exp_field;
  logic [W-1:0]     r_z;

  always_comb begin
    g = root_q[0];
    s = |rem_q;
    case (rm_q)
      3'b000:  inc = g & (s | root_q[1]);
      3'b011:  inc = g | s;
      3'b100:  inc = g;
      default: inc = 1'b0;
    endcase
    mant_sum  = {1'b0, root_q[N-2:1]} + {{MAN_W{1'b0}}, inc};
    exp_r     = ($signed(e_q) >>> 1) + BIAS;
    exp_field = exp_r[EXP_W-1:0] + {{(EXP_W-1){1'b0}}, mant_sum[MAN_W]};
    r_z       = {1'b0, exp_field, mant_sum[MAN_W-1:0]};
  end

  logic unused_bits;
  assign unused_bits = ^{root_q[M-1:N-1], exp_r[EW-1:EXP_W]};

  // Specials pass through ROUND unchanged so their latency is two edges
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_flags <= '0;
      a_q       <= '0;
      rm_q      <= '0;
      special_q <= 1'b0;
      spec_nv_q <= 1'b0;
      spec_z_q  <= '0;
      e_q       <= '0;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= in_a;
          rm_q  <= in_rm;
          state <= CLASSIFY;
        end
        CLASSIFY: begin
          special_q <= c_special;
          spec_nv_q <= c_nv;
          spec_z_q  <= c_z;
          e_q       <= e_even;
          rad_q     <= RW'({sig_even, {(MAN_W+2){1'b0}}});
          rem_q     <= '0;
          root_q    <= '0;
          cnt_q     <= '0;
          state     <= c_special ? ROUND : ITER;
        end
        ITER: begin
          rem_q  <= it_rem;
          root_q <= it_root;
          rad_q  <= it_rad;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(K - 1)) state <= ROUND;
        end
        ROUND: begin
          out_z     <= special_q ? spec_z_q : r_z;
          out_flags <= special_q ? {spec_nv_q, 4'b0000} : {4'b0000, g | s};
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fsqrt_iter.sv
// Directed bench for fsqrt_iter (binary32, UNROLL=1): values, flags, latency, backpressure, reset.
module tb_fsqrt_iter;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_a, out_z;
  logic [2:0]  in_rm;
  logic [4:0]  out_flags;

  int n_eval = 0;
  int n_fail = 0;

  localparam logic [4:0] F_NV = 5'b10000;
  localparam logic [4:0] F_NX = 5'b00001;
  localparam logic [4:0] F_0  = 5'b00000;
  localparam int LAT_N = 27;
  localparam int LAT_S = 2;

  fsqrt_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_rm(in_rm), .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_flags(out_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_eval++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for in_ready, then transfers one operand; returns #1 after the accept edge.
  task automatic start(input logic [31:0] a, input logic [2:0] rm);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    in_a = a; in_rm = rm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a  = $urandom();
    in_rm = 3'($urandom_range(0, 7));
  endtask

  // Counts edges to out_valid, checks the result, then completes the output handshake.
  task automatic finish(input string tag, input logic [31:0] ez, input logic [4:0] ef, input int elat);
    int n = 0;
    while (out_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    check({tag, " latency"}, 32'(n), 32'(elat));
    check({tag, " z"}, out_z, ez);
    check({tag, " flags"}, 32'(out_flags), 32'(ef));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " ready back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [2:0] rm,
                    input logic [31:0] ez, input logic [4:0] ef, input int elat);
    start(a, rm);
    finish(tag, ez, ef, elat);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_rm = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset busy",      32'(busy),      32'd0);
    check("reset out_z",     out_z,          32'd0);
    check("reset flags",     32'(out_flags), 32'd0);

    op("sqrt4 rne",   32'h40800000, 3'b000, 32'h40000000, F_0,  LAT_N);
    op("sqrt2 rne",   32'h40000000, 3'b000, 32'h3FB504F3, F_NX, LAT_N);
    op("sqrt2 rup",   32'h40000000, 3'b011, 32'h3FB504F4, F_NX, LAT_N);
    op("sqrt2 rtz",   32'h40000000, 3'b001, 32'h3FB504F3, F_NX, LAT_N);
    op("sqrt2 rdn",   32'h40000000, 3'b010, 32'h3FB504F3, F_NX, LAT_N);
    op("sqrt1.5 rne", 32'h3FC00000, 3'b000, 32'h3F9CC471, F_NX, LAT_N);
    op("sqrt1.5 rtz", 32'h3FC00000, 3'b001, 32'h3F9CC470, F_NX, LAT_N);
    op("sqrt1.5 rdn", 32'h3FC00000, 3'b010, 32'h3F9CC470, F_NX, LAT_N);
    op("sqrt1.5 rmm", 32'h3FC00000, 3'b100, 32'h3F9CC471, F_NX, LAT_N);
    op("maxnorm rne", 32'h7F7FFFFF, 3'b000, 32'h5F7FFFFF, F_NX, LAT_N);
    op("maxnorm rup", 32'h7F7FFFFF, 3'b011, 32'h5F800000, F_NX, LAT_N);
    op("minnorm",     32'h00800000, 3'b000, 32'h20000000, F_0,  LAT_N);
    op("subn 1ulp",   32'h00000001, 3'b000, 32'h1A3504F3, F_NX, LAT_N);
    op("subn 2^-127", 32'h00400000, 3'b000, 32'h1FB504F3, F_NX, LAT_N);

    op("neg one",   32'hBF800000, 3'b000, 32'h7FC00000, F_NV, LAT_S);
    op("neg zero",  32'h80000000, 3'b000, 32'h80000000, F_0,  LAT_S);
    op("pos zero",  32'h00000000, 3'b011, 32'h00000000, F_0,  LAT_S);
    op("snan",      32'h7F800001, 3'b000, 32'h7FC00000, F_NV, LAT_S);
    op("qnan",      32'h7FC00000, 3'b000, 32'h7FC00000, F_0,  LAT_S);
    op("pos inf",   32'h7F800000, 3'b000, 32'h7F800000, F_0,  LAT_S);
    op("neg inf",   32'hFF800000, 3'b000, 32'h7FC00000, F_NV, LAT_S);
    op("bad rm101", 32'h40800000, 3'b101, 32'h7FC00000, F_NV, LAT_S);
    op("bad rm111", 32'h40800000, 3'b111, 32'h7FC00000, F_NV, LAT_S);

    // Backpressure with a new operand already waiting
    start(32'h40800000, 3'b000);
    seen = 0;
    while (out_valid !== 1'b1 && seen < 100) begin @(posedge clk); #1; seen++; end
    check("bp latency", 32'(seen), 32'(LAT_N));
    in_a = 32'h41100000; in_rm = 3'b000; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp hold z",     out_z,           32'h40000000);
      check("bp hold flags", 32'(out_flags),  32'(F_0));
      check("bp hold ready", 32'(in_ready),   32'd0);
      check("bp hold valid", 32'(out_valid),  32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp valid drop", 32'(out_valid), 32'd0);
    check("bp ready back", 32'(in_ready),  32'd1);
    start(32'h41100000, 3'b000);
    finish("bp pending", 32'h40400000, F_0, LAT_N);

    // Reset in the middle of ITER discards the operation
    start(32'h40800000, 3'b000);
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mid rst ready", 32'(in_ready),  32'd1);
    check("mid rst busy",  32'(busy),      32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    check("mid rst no output", 32'(seen), 32'd0);
    op("after rst 9.0", 32'h41100000, 3'b000, 32'h40400000, F_0, LAT_N);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end
endmodule
